multicycle_control_unit: RTL

- Sequential successor to the single-cycle RV32IM control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with instruction/data memory (mem_ready) and an iterative multiply/divide unit (muldiv_start/muldiv_done).
- Detects illegal opcodes and memory timeouts, trapping to a sticky TRAP state.

---
 rtl/multicycle_control_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32IM control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshaking with memory and an iterative mul/div unit, and traps on illegal ops or timeouts.
module multicycle_control_unit #(
    parameter bit          ENABLE_M       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       muldiv_done,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       Jump,
    output logic       Jump_r,
    output logic       memtoreg,
    output logic       AUIPC,
    output logic [1:0] ALUOp,
    output logic       muldiv_start,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_error
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MULDIV = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [6:0]       f7_q, f7_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;

    logic op_legal;
    logic in_is_m;
    logic timeout_hit;
    logic is_load, is_store, is_branch, is_m;
    logic in_instr;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_JAL, OP_JALR, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    assign in_is_m     = (opcode == OP_R) && (funct7 == F7_MULDIV);
    assign is_load     = (op_q == OP_LOAD);
    assign is_store    = (op_q == OP_STORE);
    assign is_branch   = (op_q == OP_BRANCH);
    assign is_m        = (op_q == OP_R) && (f7_q == F7_MULDIV);
    // mem_ready on the limit cycle still completes the access
    assign timeout_hit = TIMEOUT_EN && !mem_ready && (cnt_q == CNT_LIMIT);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        f7_d        = f7_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d     = S_TRAP;
                    bus_error_d = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                f7_d = funct7;
                if (!op_legal || (in_is_m && !ENABLE_M)) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch)                 state_d = S_FETCH;
                else if (is_load || is_store)  state_d = S_MEM;
                else if (is_m)                 state_d = S_MULDIV;
                else                           state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d     = S_TRAP;
                    bus_error_d = 1'b1;
                end
            end
            S_MULDIV: begin
                if (muldiv_done) state_d = S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Any state change clears the counter, which covers entry to FETCH and MEM
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrc       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        Jump_r       = 1'b0;
        memtoreg     = 1'b0;
        AUIPC        = 1'b0;
        ALUOp        = 2'b00;
        muldiv_start = 1'b0;
        in_instr     = state_q inside {S_EXEC, S_MEM, S_MULDIV, S_WB};

        if (in_instr) begin
            case (op_q)
                OP_R:      ALUOp = 2'b10;
                OP_IMM:    begin ALUSrc = 1'b1; ALUOp = 2'b10; end
                OP_LOAD:   begin ALUSrc = 1'b1; memtoreg = 1'b1; end
                OP_STORE:  ALUSrc = 1'b1;
                OP_BRANCH: begin Branch = 1'b1; ALUOp = 2'b01; end
                OP_LUI:    begin ALUSrc = 1'b1; ALUOp = 2'b11; end
                OP_JAL:    Jump = 1'b1;
                OP_JALR:   begin ALUSrc = 1'b1; Jump_r = 1'b1; end
                OP_AUIPC:  begin ALUSrc = 1'b1; AUIPC = 1'b1; end
                default:   ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: begin
                pc_write     = is_branch;
                muldiv_start = is_m;
            end
            S_MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                pc_write = is_store && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            f7_q        <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            f7_q        <= f7_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;

endmodule
